// File: rtl/fft_bf_sequencer.sv
// fft_bf_sequencer: stage/butterfly sequencer for an in-place radix-2 DIT FFT.
// Walks LOG2N stages, issues one butterfly (A/B read address + twiddle address)
// per accepted cycle, and replays each issued address pair BF_LATENCY cycles
// later as the matching write-back strobe.
//
// Handshake: a butterfly is issued in a cycle exactly when rd_valid=1, and
// rd_valid = RUN & bf_ready. The datapath must consume the operands presented
// in that cycle; when bf_ready=0 nothing is issued and k holds. The write side
// has no back-pressure: wr_valid follows rd_valid by exactly BF_LATENCY cycles.
module fft_bf_sequencer #(
    parameter int N          = 1024,
    parameter int LOG2N      = 10,
    parameter int BF_LATENCY = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             bf_ready,
    output logic             busy,
    output logic             done,
    output logic [3:0]       stage,
    output logic             rd_valid,
    output logic [LOG2N-1:0] rd_addr_a,
    output logic [LOG2N-1:0] rd_addr_b,
    output logic [LOG2N-2:0] tw_addr,
    output logic             wr_valid,
    output logic [LOG2N-1:0] wr_addr_a,
    output logic [LOG2N-1:0] wr_addr_b,
    output logic [1:0]       dbg_state
);

    localparam int KW = LOG2N - 1;
    localparam int CW = $clog2(BF_LATENCY + 1);
    localparam logic [KW-1:0] K_LAST    = KW'(N / 2 - 1);
    localparam logic [3:0]    STAGE_LAST = 4'(LOG2N - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      stage_q, stage_d;
    logic [KW-1:0]   k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [LOG2N-1:0] k_ext, j_mask, j_val, addr_a, addr_b;
    logic [KW-1:0]    tw_val;
    logic             run;

    logic             wv_q [BF_LATENCY];
    logic [LOG2N-1:0] wa_q [BF_LATENCY];
    logic [LOG2N-1:0] wb_q [BF_LATENCY];

    // State, stage, butterfly index and drain counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            stage_q <= 4'd0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end

    // Address generation: insert a zero bit at position `stage` into k to get
    // the A index; B is A with that bit set. Twiddle is j scaled to N/2 range.
    always_comb begin
        k_ext  = {1'b0, k_q};
        j_mask = (LOG2N'(1) << stage_q) - LOG2N'(1);
        j_val  = k_ext & j_mask;
        addr_a = ((k_ext >> stage_q) << (stage_q + 4'd1)) | j_val;
        addr_b = addr_a | (LOG2N'(1) << stage_q);
        tw_val = KW'(j_val << (4'(LOG2N - 1) - stage_q));
    end

    // Next-state logic and issue outputs.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        run      = (state_q == S_RUN);
        rd_valid = run & bf_ready;
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stage_d = 4'd0;
                    k_d     = '0;
                end
            end
            S_RUN: begin
                if (bf_ready) begin
                    if (k_q == K_LAST) begin
                        state_d = S_DRAIN;
                        k_d     = '0;
                        cnt_d   = CW'(BF_LATENCY);
                    end else begin
                        k_d = k_q + KW'(1);
                    end
                end
            end
            S_DRAIN: begin
                // The last write of this stage lands in the final drain cycle,
                // so the next stage's first read never sees stale data.
                if (cnt_q == CW'(1)) begin
                    if (stage_q == STAGE_LAST) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        stage_d = stage_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                stage_d = 4'd0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Write-back delay line; advances every cycle, independent of bf_ready.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BF_LATENCY; i++) begin
                wv_q[i] <= 1'b0;
                wa_q[i] <= '0;
                wb_q[i] <= '0;
            end
        end else begin
            wv_q[0] <= rd_valid;
            wa_q[0] <= rd_valid ? addr_a : '0;
            wb_q[0] <= rd_valid ? addr_b : '0;
            for (int i = 1; i < BF_LATENCY; i++) begin
                wv_q[i] <= wv_q[i-1];
                wa_q[i] <= wa_q[i-1];
                wb_q[i] <= wb_q[i-1];
            end
        end
    end

    // Output mapping; read addresses are held at zero outside RUN.
    always_comb begin
        stage     = stage_q;
        rd_addr_a = run ? addr_a : '0;
        rd_addr_b = run ? addr_b : '0;
        tw_addr   = run ? tw_val : '0;
        wr_valid  = wv_q[BF_LATENCY-1];
        wr_addr_a = wa_q[BF_LATENCY-1];
        wr_addr_b = wb_q[BF_LATENCY-1];
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_fft_bf_sequencer.sv
// Bench for fft_bf_sequencer: small N=8 instance for exact sequence checks,
// default N=1024 instance for full-size timing and mid-transform reset.
module tb_fft_bf_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Small instance: N=8, LOG2N=3, BF_LATENCY=2
    logic       s_rst_n, s_start, s_ready;
    logic       s_busy, s_done, s_rdv, s_wrv;
    logic [3:0] s_stage;
    logic [2:0] s_ra, s_rb, s_wa, s_wb;
    logic [1:0] s_tw, s_dbg;

    // Default instance: N=1024, LOG2N=10, BF_LATENCY=4
    logic       b_rst_n, b_start, b_ready;
    logic       b_busy, b_done, b_rdv, b_wrv;
    logic [3:0] b_stage;
    logic [9:0] b_ra, b_rb, b_wa, b_wb;
    logic [8:0] b_tw;
    logic [1:0] b_dbg;

    fft_bf_sequencer #(.N(8), .LOG2N(3), .BF_LATENCY(2)) u_small (
        .clk(clk), .reset_n(s_rst_n), .start(s_start), .bf_ready(s_ready),
        .busy(s_busy), .done(s_done), .stage(s_stage), .rd_valid(s_rdv),
        .rd_addr_a(s_ra), .rd_addr_b(s_rb), .tw_addr(s_tw),
        .wr_valid(s_wrv), .wr_addr_a(s_wa), .wr_addr_b(s_wb), .dbg_state(s_dbg)
    );

    fft_bf_sequencer u_big (
        .clk(clk), .reset_n(b_rst_n), .start(b_start), .bf_ready(b_ready),
        .busy(b_busy), .done(b_done), .stage(b_stage), .rd_valid(b_rdv),
        .rd_addr_a(b_ra), .rd_addr_b(b_rb), .tw_addr(b_tw),
        .wr_valid(b_wrv), .wr_addr_a(b_wa), .wr_addr_b(b_wb), .dbg_state(b_dbg)
    );

    // Hand-computed N=8 read sequence (stage 0, 1, 2)
    logic [2:0] exp_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [2:0] exp_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [1:0] exp_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

    function automatic logic [63:0] rng(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    // Drives the small instance cycle by cycle from bit masks indexed by cycle
    // number (cycle 0 = first start cycle) and checks every output per cycle.
    task automatic run_small(input logic [63:0] start_m, input logic [63:0] low_m,
                             input logic [63:0] rd_m, input logic [63:0] wr_m,
                             input logic [63:0] done_m, input logic [63:0] busy_m,
                             input int t_end, input string name);
        logic [5:0] exp_q[$];
        logic [5:0] got;
        int idx;
        idx = 0;
        exp_q.delete();
        for (int t = 0; t <= t_end; t++) begin
            @(negedge clk);
            s_start = start_m[t];
            s_ready = !low_m[t];
            #1;
            checks++;
            if (s_rdv !== rd_m[t]) begin
                errors++;
                $display("FAIL %s rd_valid t=%0d: got %b exp %b", name, t, s_rdv, rd_m[t]);
            end
            if (rd_m[t] && s_rdv === 1'b1) begin
                checks++;
                if ({s_ra, s_rb, s_tw, s_stage} !== {exp_a[idx%12], exp_b[idx%12], exp_tw[idx%12], 4'((idx%12)/4)}) begin
                    errors++;
                    $display("FAIL %s rd_addr t=%0d: got a=%0d b=%0d tw=%0d st=%0d exp a=%0d b=%0d tw=%0d st=%0d",
                             name, t, s_ra, s_rb, s_tw, s_stage,
                             exp_a[idx%12], exp_b[idx%12], exp_tw[idx%12], (idx%12)/4);
                end
                exp_q.push_back({exp_a[idx%12], exp_b[idx%12]});
                idx++;
            end
            checks++;
            if (s_wrv !== wr_m[t]) begin
                errors++;
                $display("FAIL %s wr_valid t=%0d: got %b exp %b", name, t, s_wrv, wr_m[t]);
            end
            if (wr_m[t] && s_wrv === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s wr_queue t=%0d: got write exp no pending read", name, t);
                end else begin
                    got = exp_q.pop_front();
                    if ({s_wa, s_wb} !== got) begin
                        errors++;
                        $display("FAIL %s wr_addr t=%0d: got a=%0d b=%0d exp a=%0d b=%0d",
                                 name, t, s_wa, s_wb, got[5:3], got[2:0]);
                    end
                end
            end
            checks++;
            if ({s_done, s_busy} !== {done_m[t], busy_m[t]}) begin
                errors++;
                $display("FAIL %s done/busy t=%0d: got %b/%b exp %b/%b",
                         name, t, s_done, s_busy, done_m[t], busy_m[t]);
            end
        end
        s_start = 1'b0;
        s_ready = 1'b1;
    endtask

    task automatic test_reset();
        s_rst_n = 1'b0; b_rst_n = 1'b0;
        s_start = 1'b0; b_start = 1'b0;
        s_ready = 1'b1; b_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({s_busy, s_done, s_rdv, s_wrv, s_stage} !== 8'd0) begin
            errors++;
            $display("FAIL reset_small_ctrl: got %b exp 0", {s_busy, s_done, s_rdv, s_wrv, s_stage});
        end
        checks++;
        if ({s_ra, s_rb, s_tw, s_wa, s_wb} !== 14'd0) begin
            errors++;
            $display("FAIL reset_small_addr: got %h exp 0", {s_ra, s_rb, s_tw, s_wa, s_wb});
        end
        checks++;
        if ({b_busy, b_done, b_rdv, b_wrv, b_stage} !== 8'd0) begin
            errors++;
            $display("FAIL reset_big_ctrl: got %b exp 0", {b_busy, b_done, b_rdv, b_wrv, b_stage});
        end
        checks++;
        if ({b_ra, b_rb, b_tw, b_wa, b_wb} !== 49'd0) begin
            errors++;
            $display("FAIL reset_big_addr: got %h exp 0", {b_ra, b_rb, b_tw, b_wa, b_wb});
        end
        @(negedge clk);
        s_rst_n = 1'b1; b_rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_sequence();
        run_small(rng(0, 0), 64'd0,
                  rng(1, 4) | rng(7, 10) | rng(13, 16),
                  rng(3, 6) | rng(9, 12) | rng(15, 18),
                  rng(19, 19), rng(1, 18), 24, "seq");
    endtask

    task automatic test_start_ignored();
        run_small(rng(0, 0) | rng(3, 3) | rng(5, 5) | rng(19, 19), 64'd0,
                  rng(1, 4) | rng(7, 10) | rng(13, 16),
                  rng(3, 6) | rng(9, 12) | rng(15, 18),
                  rng(19, 19), rng(1, 18), 24, "start_ign");
    endtask

    task automatic test_stall();
        run_small(rng(0, 0), rng(8, 10),
                  rng(1, 4) | rng(7, 7) | rng(11, 13) | rng(16, 19),
                  rng(3, 6) | rng(9, 9) | rng(13, 15) | rng(18, 21),
                  rng(22, 22), rng(1, 21), 27, "stall");
    endtask

    task automatic test_back_to_back();
        logic [63:0] rd1, wr1;
        rd1 = rng(1, 4) | rng(7, 10) | rng(13, 16);
        wr1 = rng(3, 6) | rng(9, 12) | rng(15, 18);
        run_small(rng(0, 0) | rng(20, 20), 64'd0,
                  rd1 | (rd1 << 20), wr1 | (wr1 << 20),
                  rng(19, 19) | rng(39, 39), rng(1, 18) | rng(21, 38), 44, "b2b");
    endtask

    // Full-size run, no stalls: rd at t where (t-1) mod 516 < 512, wr 4 later.
    task automatic test_full_size();
        int rd_cnt, wr_cnt, done_cyc, rd_bad, wr_bad;
        bit exp_rd, exp_wr;
        rd_cnt = 0; wr_cnt = 0; done_cyc = -1; rd_bad = 0; wr_bad = 0;
        for (int t = 0; t <= 5200; t++) begin
            @(negedge clk);
            b_start = (t == 0);
            b_ready = 1'b1;
            #1;
            exp_rd = (t >= 1 && t <= 5160 && ((t - 1) % 516) < 512);
            exp_wr = (t >= 5 && t <= 5164 && ((t - 5) % 516) < 512);
            if (b_rdv !== exp_rd) rd_bad++;
            if (b_wrv !== exp_wr) wr_bad++;
            if (b_rdv === 1'b1) rd_cnt++;
            if (b_wrv === 1'b1) wr_cnt++;
            if (b_done === 1'b1 && done_cyc < 0) begin
                done_cyc = t;
                checks++;
                if (b_busy !== 1'b0) begin
                    errors++;
                    $display("FAIL full_busy_at_done: got %b exp 0", b_busy);
                end
            end
            if (t >= 1 && t <= 4645 && ((t - 1) % 516) == 0) begin
                checks++;
                if (b_stage !== 4'((t - 1) / 516)) begin
                    errors++;
                    $display("FAIL full_stage t=%0d: got %0d exp %0d", t, b_stage, (t - 1) / 516);
                end
            end
            if (t == 2618) begin
                checks++;
                if ({b_ra, b_rb, b_tw} !== {10'd69, 10'd101, 9'd80}) begin
                    errors++;
                    $display("FAIL full_addr_s5: got a=%0d b=%0d tw=%0d exp a=69 b=101 tw=80", b_ra, b_rb, b_tw);
                end
            end
            if (t == 5156) begin
                checks++;
                if ({b_ra, b_rb, b_tw} !== {10'd511, 10'd1023, 9'd511}) begin
                    errors++;
                    $display("FAIL full_addr_s9: got a=%0d b=%0d tw=%0d exp a=511 b=1023 tw=511", b_ra, b_rb, b_tw);
                end
            end
            if (t == 5160) begin
                checks++;
                if ({b_wrv, b_wa, b_wb} !== {1'b1, 10'd511, 10'd1023}) begin
                    errors++;
                    $display("FAIL full_last_wr: got v=%b a=%0d b=%0d exp v=1 a=511 b=1023", b_wrv, b_wa, b_wb);
                end
            end
        end
        checks++;
        if (done_cyc != 5161) begin
            errors++;
            $display("FAIL full_done_cycle: got %0d exp 5161", done_cyc);
        end
        checks++;
        if (rd_cnt != 5120 || wr_cnt != 5120) begin
            errors++;
            $display("FAIL full_counts: got rd=%0d wr=%0d exp 5120/5120", rd_cnt, wr_cnt);
        end
        checks++;
        if (rd_bad != 0 || wr_bad != 0) begin
            errors++;
            $display("FAIL full_timing: got %0d rd and %0d wr off-schedule cycles exp 0", rd_bad, wr_bad);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        bad = 0;
        for (int t = 0; t < 2681; t++) begin
            @(negedge clk);
            b_start = (t == 0);
            b_ready = 1'b1;
        end
        #1;
        checks++;
        if ({b_stage, b_wrv, b_busy} !== {4'd5, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL rmid_precond: got st=%0d wr=%b busy=%b exp 5/1/1", b_stage, b_wrv, b_busy);
        end
        @(negedge clk);
        b_rst_n = 1'b0;
        #1;
        checks++;
        if ({b_busy, b_done, b_rdv, b_wrv, b_stage} !== 8'd0 || {b_ra, b_rb, b_tw, b_wa, b_wb} !== 49'd0) begin
            errors++;
            $display("FAIL rmid_async: got ctrl=%b addr=%h exp 0", {b_busy, b_done, b_rdv, b_wrv, b_stage},
                     {b_ra, b_rb, b_tw, b_wa, b_wb});
        end
        repeat (2) @(negedge clk);
        b_rst_n = 1'b1;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            #1;
            if ({b_busy, b_done, b_rdv, b_wrv} !== 4'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL rmid_idle_after: got %0d active cycles exp 0", bad);
        end
        @(negedge clk);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        #1;
        checks++;
        if ({b_busy, b_rdv, b_stage, b_ra, b_rb, b_tw} !== {1'b1, 1'b1, 4'd0, 10'd0, 10'd1, 9'd0}) begin
            errors++;
            $display("FAIL rmid_restart: got busy=%b rd=%b st=%0d a=%0d b=%0d tw=%0d exp 1/1/0/0/1/0",
                     b_busy, b_rdv, b_stage, b_ra, b_rb, b_tw);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_start_ignored();
        test_stall();
        test_back_to_back();
        test_full_size();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fft_bf_sequencer.md
# fft_bf_sequencer

Control sequencer for the in-place radix-2 FFT datapath (sample RAM, twiddle ROM, complex butterfly). After `start`, it walks all LOG2N stages and issues one butterfly per cycle: the A/B read addresses and the twiddle address. It delays each address pair by the butterfly pipeline latency to produce matching write-back strobes. It sits between the top-level LOAD/OUTPUT state machine and the butterfly/RAM datapath, and replaces ad-hoc stage/butterfly counting in the FFT top.

## Interface
- N, 1024, FFT points (power of two, ≥ 4)
- LOG2N, 10, log2(N)
- BF_LATENCY, 4, cycles from butterfly operand read to result write (≥ 1)
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  begin transform; sampled only in IDLE
- bf_ready  in  1  datapath can accept a butterfly this cycle (RUN only)
- busy  out  1  high in RUN and DRAIN
- done  out  1  one-cycle pulse at end of last stage
- stage  out  4  current stage index, 0..LOG2N-1
- rd_valid  out  1  butterfly issued this cycle
- rd_addr_a / rd_addr_b  out  LOG2N  operand addresses
- tw_addr  out  LOG2N-1  twiddle ROM address
- wr_valid  out  1  result write strobe
- wr_addr_a / wr_addr_b  out  LOG2N  result addresses

## Operation
- The sample RAM holds the input in bit-reversed order. This is decimation-in-time: output is natural order, written in place.
- States:
  - IDLE: busy=0. `start` → RUN with stage=0, k=0.
  - RUN: issues butterflies k = 0..N/2-1.
  - DRAIN: waits for in-flight writes.
  - DONE: done=1 for one cycle, then IDLE.
- RUN issue rules:
  - rd_valid = (state==RUN) & bf_ready. rd_addr_* and tw_addr are combinational from the registered stage and k.
  - k increments only when rd_valid=1.
  - When rd_valid=1 with k==N/2-1: next state is DRAIN with drain counter = BF_LATENCY, and k resets to 0.
- Address generation for stage s, span = 2^s, j = k mod span:
  - rd_addr_a = ((k >> s) << (s+1)) | j
  - rd_addr_b = rd_addr_a + span
  - tw_addr = j << (LOG2N-1-s)
- DRAIN: decrement the counter each cycle. When it reaches 1:
  - if stage == LOG2N-1 → DONE;
  - else stage+1 → RUN.
- DRAIN ignores bf_ready.
- Write pipeline: a BF_LATENCY-deep shift register of {valid, addr_a, addr_b}, advancing every cycle regardless of bf_ready.
  - wr_valid/wr_addr_* are its output stage, so wr_valid pulses exactly BF_LATENCY cycles after the matching rd_valid.
- `start` outside IDLE is ignored. No abort input exists; reset_n is the only abort.

## Timing
- Reset (async assert, sync release behaviour): state=IDLE, stage=0, k=0, pipeline cleared. All outputs 0: busy, done, rd_valid, wr_valid, addresses.
- Reset mid-transform: in-flight writes are discarded immediately (wr_valid=0 during and after reset). The RAM contents are undefined to the caller.
- `start` sampled high at cycle 0 → RUN at cycle 1; first rd_valid at cycle 1 if bf_ready=1.
- Without stalls, each stage takes N/2 + BF_LATENCY cycles. done is high at cycle 1 + LOG2N·(N/2+BF_LATENCY), i.e. cycle 5161 for the defaults. busy falls in the same cycle done rises.
- Each stall cycle (bf_ready=0 in RUN) delays done by exactly 1 cycle.
- The last write of stage s occurs in the final DRAIN cycle. The first read of stage s+1 occurs the next cycle, so there is no RAW hazard between stages.
- Within a stage, no address is read after being written.
- `stage` output changes in the first RUN cycle of the new stage.

## Test plan
- N=8, LOG2N=3, BF_LATENCY=2, bf_ready=1, start at cycle 0 → required read sequence:
  - stage0: (0,1),(2,3),(4,5),(6,7), all tw=0
  - stage1: (0,2)tw0, (1,3)tw2, (4,6)tw0, (5,7)tw2
  - stage2: (0,4)tw0, (1,5)tw1, (2,6)tw2, (3,7)tw3
  - done at cycle 19
- Same config: every wr_valid occurs exactly 2 cycles after its rd_valid with identical addresses. 12 writes total; none after done.
- Default N=1024, L=4, no stalls → done at cycle 5161; 5120 rd_valid and 5120 wr_valid pulses; stage steps 0..9.
- N=8: bf_ready low for 3 cycles mid stage1 → no rd_valid during the stall, k held, writes already issued still appear on schedule; done at cycle 22.
- `start` pulsed during RUN/DRAIN/DONE → ignored. Back-to-back: start in the IDLE cycle after done begins a fresh transform with stage=0.
- reset_n asserted mid stage 5 → all outputs 0 immediately. After release, the block stays in IDLE until start; no residual wr_valid.
